// File: rtl/sync_fifo_lvl.sv
// Single-clock show-ahead FIFO with fill-level count, almost-full/almost-empty
// thresholds and sticky overflow/underflow error flags.
module sync_fifo_lvl #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = 14,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rinc,
    input  logic             clr_err,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             walmost_full,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int              DEPTH      = 1 << ASIZE;
    localparam logic [ASIZE:0]  DEPTH_CNT  = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0]  AFULL_CNT  = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0]  AEMPTY_CNT = (ASIZE+1)'(AEMPTY_TH);

    logic [DSIZE-1:0] mem [DEPTH];

    logic [ASIZE-1:0] waddr_reg;
    logic [ASIZE-1:0] raddr_reg;
    logic [ASIZE:0]   count_reg;
    logic [ASIZE:0]   count_next;
    logic             overflow_reg;
    logic             underflow_reg;

    logic do_write;
    logic do_read;

    // Flags come straight from the registered count, so they settle with it.
    assign wfull         = (count_reg == DEPTH_CNT);
    assign rempty        = (count_reg == '0);
    assign walmost_full  = (count_reg >= AFULL_CNT);
    assign ralmost_empty = (count_reg <= AEMPTY_CNT);
    assign count         = count_reg;
    assign overflow      = overflow_reg;
    assign underflow     = underflow_reg;

    assign do_write = winc & ~wfull;
    assign do_read  = rinc & ~rempty;

    assign rdata = rempty ? '0 : mem[raddr_reg];

    always_comb begin
        count_next = count_reg;
        if (do_write && !do_read) begin
            count_next = count_reg + 1'b1;
        end else if (!do_write && do_read) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Storage carries no reset; stale words are hidden behind count == 0.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[waddr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_reg <= '0;
            raddr_reg <= '0;
            count_reg <= '0;
        end else begin
            if (do_write) begin
                waddr_reg <= waddr_reg + 1'b1;
            end
            if (do_read) begin
                raddr_reg <= raddr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    // A clear in the same cycle as a new error wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (clr_err) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (winc && wfull) begin
                overflow_reg <= 1'b1;
            end
            if (rinc && rempty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

endmodule
